// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
package dmem_pkg;

  // Access size encodings (req_size)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Controller FSM state type and encodings
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LD_WAIT = 3'd1;
  localparam state_t ST_RMW_RD  = 3'd2;
  localparam state_t ST_RMW_WR  = 3'd3;
  localparam state_t ST_ERR     = 3'd4;

  // True when the access cannot be served: unaligned half/word or reserved size
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data_c,
  output logic [31:0] merge_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_wdata;

  assign byte_sel     = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel     = rdata[{addr_lo[1], 4'b0000} +: 16];
  assign unused_wdata = ^wdata[31:16];

  // Load path: pick the addressed lane and sign/zero extend it
  always_comb begin
    load_data_c = '0;
    case (size)
      SZ_BYTE: load_data_c = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_c = {{16{sign_ext & half_sel[15]}}, half_sel};
      SZ_WORD: load_data_c = rdata;
      default: load_data_c = '0;
    endcase
  end

  // Store path: overwrite the addressed lane of the old word with new data
  always_comb begin
    merge_data_c = rdata;
    case (size)
      SZ_BYTE: merge_data_c[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merge_data_c[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage access controller sequencing a single-port word-wide DataMemory.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] merge_q;
  logic [31:0] load_data_c;
  logic [31:0] merge_data_c;
  logic        bad_c;
  logic        unused_addr;

  assign bad_c       = is_misaligned(req_size, req_addr[1:0]);
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  dmem_lane_unit u_lane (
    .size         (req_size),
    .sign_ext     (req_signed),
    .addr_lo      (req_addr[1:0]),
    .rdata        (mem_dout),
    .wdata        (req_wdata),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Merge register: old word with the store lane replaced, written back in RMW_WR
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     merge_q <= '0;
    else if (state_q == ST_RMW_RD && req_valid) merge_q <= merge_data_c;
  end

  // Next state and outputs; everything is forced low while rst is high
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    misalign  = 1'b0;
    mem_we    = 1'b0;
    mem_din   = '0;
    mem_addr  = rst ? '0 : req_addr[ADDR_W+1:2];
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (bad_c) begin
              stall   = 1'b1;
              state_d = ST_ERR;
            end else if (req_we && req_size == SZ_WORD) begin
              mem_we  = 1'b1;
              mem_din = req_wdata;
            end else if (req_we) begin
              stall   = 1'b1;
              state_d = ST_RMW_RD;
            end else begin
              stall   = 1'b1;
              state_d = ST_LD_WAIT;
            end
          end
        end
        ST_LD_WAIT: begin
          state_d = ST_IDLE;
          if (req_valid) begin
            rsp_valid = 1'b1;
            rsp_rdata = load_data_c;
          end
        end
        ST_RMW_RD: begin
          if (req_valid) begin
            stall   = 1'b1;
            state_d = ST_RMW_WR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RMW_WR: begin
          state_d = ST_IDLE;
          if (req_valid) begin
            mem_we  = 1'b1;
            mem_din = merge_q;
          end
        end
        ST_ERR: begin
          state_d  = ST_IDLE;
          misalign = req_valid;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
